// File: rtl/reg_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : reg_operand_fetch
// Summary  : Integer register file, pending-write scoreboard and operand select
//            between decode and execute, with valid/ready on both sides.
//            Define REG_OPERAND_FETCH_BYPASS_EN to forward write-back data.
// Revision : 1.0 - initial release
// ============================================================================
module reg_operand_fetch #(
    parameter  int XLEN     = 32,
    parameter  int NUM_REGS = 32,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   in_rs1_addr,
    input  logic [AW-1:0]   in_rs2_addr,
    input  logic [AW-1:0]   in_rd_addr,
    input  logic            in_rd_we,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic [1:0]      in_op1_sel,
    input  logic [2:0]      in_op2_sel,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [AW-1:0]   out_rd_addr,
    output logic            out_rd_we
);

    localparam logic [1:0]    c_OP1_X   = 2'd0;
    localparam logic [1:0]    c_OP1_RS1 = 2'd1;
    localparam logic [1:0]    c_OP1_PC  = 2'd2;
    localparam logic [2:0]    c_OP2_X   = 3'd0;
    localparam logic [2:0]    c_OP2_RS2 = 3'd1;
    localparam logic [2:0]    c_OP2_IMI = 3'd2;
    localparam logic [2:0]    c_OP2_IMS = 3'd3;
    localparam logic [2:0]    c_OP2_IMJ = 3'd4;
    localparam logic [2:0]    c_OP2_IMU = 3'd5;
    localparam logic [AW-1:0] c_X0      = '0;

    logic [XLEN-1:0]     r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] w_busy;

    logic                r_out_valid;
    logic [XLEN-1:0]     r_out_op1;
    logic [XLEN-1:0]     r_out_op2;
    logic [AW-1:0]       r_out_rd_addr;
    logic                r_out_rd_we;

    logic                w_use_rs1;
    logic                w_use_rs2;
    logic                w_fwd_rs1;
    logic                w_fwd_rs2;
    logic                w_hazard;
    logic                w_ready;
    logic                w_accept;
    logic [XLEN-1:0]     w_rs1_val;
    logic [XLEN-1:0]     w_rs2_val;
    logic [XLEN-1:0]     w_op1;
    logic [XLEN-1:0]     w_op2;

    assign w_use_rs1 = (in_op1_sel == c_OP1_RS1);
    assign w_use_rs2 = (in_op2_sel == c_OP2_RS2);

`ifdef REG_OPERAND_FETCH_BYPASS_EN
    assign w_fwd_rs1 = wb_en && (wb_addr != c_X0) && (wb_addr == in_rs1_addr);
    assign w_fwd_rs2 = wb_en && (wb_addr != c_X0) && (wb_addr == in_rs2_addr);
`else
    assign w_fwd_rs1 = 1'b0;
    assign w_fwd_rs2 = 1'b0;
`endif

    // Without forwarding a same-cycle write is not visible; the busy stall makes that safe.
    assign w_rs1_val = w_fwd_rs1              ? wb_data :
                       (in_rs1_addr == c_X0)  ? '0      : r_regs[in_rs1_addr];
    assign w_rs2_val = w_fwd_rs2              ? wb_data :
                       (in_rs2_addr == c_X0)  ? '0      : r_regs[in_rs2_addr];

    assign w_hazard = (w_use_rs1 && w_busy[in_rs1_addr] && !w_fwd_rs1) ||
                      (w_use_rs2 && w_busy[in_rs2_addr] && !w_fwd_rs2);

    assign w_ready  = (!r_out_valid || out_ready) && !w_hazard;
    assign w_accept = in_valid && w_ready;

    always_comb begin
        w_op1 = '0;
        case (in_op1_sel)
            c_OP1_X:   w_op1 = '0;
            c_OP1_RS1: w_op1 = w_rs1_val;
            c_OP1_PC:  w_op1 = in_pc;
            default:   w_op1 = '0;
        endcase
    end

    always_comb begin
        w_op2 = '0;
        case (in_op2_sel)
            c_OP2_X:   w_op2 = '0;
            c_OP2_RS2: w_op2 = w_rs2_val;
            c_OP2_IMI,
            c_OP2_IMS,
            c_OP2_IMJ,
            c_OP2_IMU: w_op2 = in_imm;
            default:   w_op2 = '0;
        endcase
    end

    // x0 is never written, so its entry stays at the reset value of zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_en && (wb_addr != c_X0)) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    // A new reservation outranks a same-cycle write-back release of that register.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_busy
        if (g == 0) begin : g_zero
            assign w_busy[g] = 1'b0;
        end else begin : g_bit
            logic r_bit;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_bit <= 1'b0;
                end else if (w_accept && in_rd_we && (in_rd_addr == AW'(g))) begin
                    r_bit <= 1'b1;
                end else if (wb_en && (wb_addr == AW'(g))) begin
                    r_bit <= 1'b0;
                end
            end
            assign w_busy[g] = r_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid   <= 1'b0;
            r_out_op1     <= '0;
            r_out_op2     <= '0;
            r_out_rd_addr <= '0;
            r_out_rd_we   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid   <= 1'b1;
            r_out_op1     <= w_op1;
            r_out_op2     <= w_op2;
            r_out_rd_addr <= in_rd_addr;
            r_out_rd_we   <= in_rd_we;
        end else if (out_ready) begin
            r_out_valid   <= 1'b0;
        end
    end

    assign in_ready    = w_ready;
    assign out_valid   = r_out_valid;
    assign out_op1     = r_out_op1;
    assign out_op2     = r_out_op2;
    assign out_rd_addr = r_out_rd_addr;
    assign out_rd_we   = r_out_rd_we;

endmodule
`default_nettype wire

// File: tb/tb_reg_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_operand_fetch
// Summary  : Directed and random bench for reg_operand_fetch against a
//            register/scoreboard reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_operand_fetch;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;
    localparam int AW       = 5;
`ifdef REG_OPERAND_FETCH_BYPASS_EN
    localparam bit c_BYP = 1'b1;
`else
    localparam bit c_BYP = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [AW-1:0]   in_rs1_addr;
    logic [AW-1:0]   in_rs2_addr;
    logic [AW-1:0]   in_rd_addr;
    logic            in_rd_we;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_imm;
    logic [1:0]      in_op1_sel;
    logic [2:0]      in_op2_sel;
    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_op1;
    logic [XLEN-1:0] out_op2;
    logic [AW-1:0]   out_rd_addr;
    logic            out_rd_we;

    reg_operand_fetch #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we),
        .in_pc(in_pc), .in_imm(in_imm),
        .in_op1_sel(in_op1_sel), .in_op2_sel(in_op2_sel),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2),
        .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: architectural registers, pending writes, output stage.
    logic [XLEN-1:0] m_regs [NUM_REGS];
    bit              m_busy [NUM_REGS];
    logic            m_vld;
    logic [XLEN-1:0] m_op1;
    logic [XLEN-1:0] m_op2;
    logic [AW-1:0]   m_rd;
    logic            m_we;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit fwd(input logic [AW-1:0] a);
        return c_BYP && wb_en && (wb_addr == a) && (a != 0);
    endfunction

    function automatic logic [XLEN-1:0] src(input logic [AW-1:0] a);
        if (fwd(a)) return wb_data;
        if (a == 0) return '0;
        return m_regs[a];
    endfunction

    function automatic bit exp_ready();
        bit stall;
        stall = ((in_op1_sel == 2'd1) && m_busy[in_rs1_addr] && !fwd(in_rs1_addr)) ||
                ((in_op2_sel == 3'd1) && m_busy[in_rs2_addr] && !fwd(in_rs2_addr));
        return (!m_vld || out_ready) && !stall;
    endfunction

    function automatic logic [XLEN-1:0] want_op1();
        if (in_op1_sel == 2'd1) return src(in_rs1_addr);
        if (in_op1_sel == 2'd2) return in_pc;
        return '0;
    endfunction

    function automatic logic [XLEN-1:0] want_op2();
        if (in_op2_sel == 3'd1) return src(in_rs2_addr);
        if (in_op2_sel >= 3'd2 && in_op2_sel <= 3'd5) return in_imm;
        return '0;
    endfunction

    // One clock: check in_ready before the edge, advance the model, check outputs after.
    task automatic tick();
        bit er, acc;
        logic [XLEN-1:0] v1, v2;
        #1;
        er = exp_ready();
        if (!rst) chk("in_ready", in_ready, er);
        acc = in_valid && er && !rst;
        v1  = want_op1();
        v2  = want_op2();
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
            m_vld = 1'b0; m_op1 = '0; m_op2 = '0; m_rd = '0; m_we = 1'b0;
        end else begin
            if (wb_en) m_busy[wb_addr] = 1'b0;
            if (acc && in_rd_we && in_rd_addr != 0) m_busy[in_rd_addr] = 1'b1;
            if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
            if (acc) begin
                m_vld = 1'b1; m_op1 = v1; m_op2 = v2; m_rd = in_rd_addr; m_we = in_rd_we;
            end else if (out_ready) begin
                m_vld = 1'b0;
            end
        end
        chk("out_valid", out_valid, m_vld);
        chk("out_op1", out_op1, m_op1);
        chk("out_op2", out_op2, m_op2);
        chk("out_rd_addr", out_rd_addr, m_rd);
        chk("out_rd_we", out_rd_we, m_we);
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 0; in_rs1_addr = 0; in_rs2_addr = 0; in_rd_addr = 0; in_rd_we = 0;
        in_pc = 0; in_imm = 0; in_op1_sel = 0; in_op2_sel = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0; out_ready = 1;
    endtask

    task automatic issue(input logic [1:0] s1, input logic [AW-1:0] r1,
                         input logic [2:0] s2, input logic [AW-1:0] r2,
                         input logic [AW-1:0] rd, input logic we,
                         input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm);
        in_valid = 1; in_op1_sel = s1; in_rs1_addr = r1; in_op2_sel = s2; in_rs2_addr = r2;
        in_rd_addr = rd; in_rd_we = we; in_pc = pc; in_imm = imm;
    endtask

    task automatic wb(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wb_en = 1; wb_addr = a; wb_data = d;
    endtask

    initial begin
        int q[$];
        m_vld = 0; m_op1 = 0; m_op2 = 0; m_rd = 0; m_we = 0;
        for (int i = 0; i < NUM_REGS; i++) begin m_regs[i] = '0; m_busy[i] = 0; end
        idle();
        rst = 1;
        @(negedge clk);
        // Reset alongside a write-back: the write must be lost.
        wb(5, 32'hDEAD);
        tick();
        rst = 0; idle();
        tick();
        issue(2'd1, 5, 3'd0, 0, 0, 0, 0, 0); tick(); idle();
        chk("x5_after_reset", out_op1, 0);

        wb(3, 32'h1234); tick(); idle();
        issue(2'd1, 3, 3'd2, 0, 0, 0, 0, 32'hFFFF_FFF0); tick(); idle();
        chk("rs1_x3", out_op1, 32'h1234);
        chk("imi", out_op2, 32'hFFFF_FFF0);

        wb(0, 32'h55); tick(); idle();
        issue(2'd1, 0, 3'd1, 0, 0, 0, 0, 0); tick(); idle();
        chk("x0_op1", out_op1, 0);
        chk("x0_op2", out_op2, 0);

        // RAW hazard on x7 resolved by write-back.
        issue(2'd0, 0, 3'd0, 0, 7, 1, 0, 0); tick();
        issue(2'd1, 7, 3'd0, 0, 0, 0, 0, 0); tick(); tick();
        wb(7, 32'hABCD); tick();
        wb_en = 0; tick();
        idle(); tick();
        chk("raw_x7", out_op1, 32'hABCD);

        // Output back-pressure.
        issue(2'd2, 0, 3'd2, 0, 9, 1, 32'h100, 32'h11); tick();
        out_ready = 0;
        issue(2'd2, 0, 3'd3, 0, 10, 0, 32'h104, 32'h22); tick(); tick(); tick();
        chk("held_op1", out_op1, 32'h100);
        out_ready = 1; tick();
        idle(); tick();
        wb(9, 32'h9); tick(); idle();

        // Unused busy source must not stall.
        issue(2'd0, 0, 3'd0, 0, 1, 1, 0, 0); tick();
        issue(2'd2, 1, 3'd0, 0, 0, 0, 32'h8000_0004, 0); tick(); idle();
        chk("pc_op1", out_op1, 32'h8000_0004);
        chk("pc_op2", out_op2, 0);
        wb(1, 32'h1); tick(); idle();

        for (int n = 0; n < 500; n++) begin
            in_valid    = ($urandom % 4) != 0;
            in_rs1_addr = AW'($urandom_range(0, 7));
            in_rs2_addr = AW'($urandom_range(0, 7));
            in_rd_addr  = AW'($urandom_range(0, 7));
            in_rd_we    = $urandom % 2;
            in_op1_sel  = 2'($urandom % 4);
            in_op2_sel  = 3'($urandom % 8);
            in_pc       = $urandom;
            in_imm      = $urandom;
            out_ready   = ($urandom % 4) != 0;
            q.delete();
            for (int i = 0; i < NUM_REGS; i++) if (m_busy[i]) q.push_back(i);
            wb_en   = ($urandom % 2) != 0;
            wb_addr = (q.size() > 0 && ($urandom % 4) != 0) ?
                      AW'(q[$urandom_range(0, q.size() - 1)]) : AW'($urandom_range(0, 7));
            wb_data = $urandom;
            tick();
        end
        idle(); tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_operand_fetch.md
Name: reg_operand_fetch

Overview:
- Parametrised successor to the decode-stage register file and operand mux. Holds the integer register file and selects operand 1 (zero/rs1/pc) and operand 2 (zero/rs2/imm).
- Adds what the earlier block lacks:
  - x0 hard-wired to zero;
  - a pending-write scoreboard with hazard stall;
  - a valid/ready handshake on both sides;
  - optional write-back forwarding.
- Sits between decode and execute; write-back drives the write port.

Parameters:
- XLEN, 32, data/pc/imm width in bits.
- NUM_REGS, 32, number of architectural registers; power of two, at least 2.
- AW, $clog2(NUM_REGS), register address width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_rs1_addr  in  AW  operand 1 source register.
- in_rs2_addr  in  AW  operand 2 source register.
- in_rd_addr  in  AW  destination register.
- in_rd_we  in  1  instruction will write in_rd_addr at write-back.
- in_pc  in  XLEN  instruction pc.
- in_imm  in  XLEN  decoded immediate.
- in_op1_sel  in  2  0=X(zero), 1=RS1, 2=PC, 3=reserved.
- in_op2_sel  in  3  0=X(zero), 1=RS2, 2=IMI, 3=IMS, 4=IMJ, 5=IMU, 6-7=reserved.
- wb_en  in  1  write-back strobe.
- wb_addr  in  AW  write-back register.
- wb_data  in  XLEN  write-back value.
- out_valid  out  1  operands valid.
- out_ready  in  1  execute accepts the operands.
- out_op1  out  XLEN  selected operand 1.
- out_op2  out  XLEN  selected operand 2.
- out_rd_addr  out  AW  registered destination.
- out_rd_we  out  1  registered write enable.

Behaviour:
- Reset: out_valid=0, out_op1=0, out_op2=0, out_rd_addr=0, out_rd_we=0. All registers cleared to 0. All scoreboard busy bits cleared. Reset overrides any handshake or write-back in the same cycle.
- Register file:
  - Write at posedge when wb_en and wb_addr!=0.
  - Writes to x0 are ignored; a read of x0 always returns 0.
- Scoreboard, busy[NUM_REGS]:
  - An accepted instruction (in_valid & in_ready) with in_rd_we and in_rd_addr!=0 sets busy[in_rd_addr].
  - wb_en clears busy[wb_addr].
  - Same register set and cleared in the same cycle: set wins.
  - busy[0] is always 0.
- Source use:
  - rs1 is used only when op1_sel=RS1.
  - rs2 is used only when op2_sel=RS2.
  - Unused sources never cause a stall.
- Hazard: a used source with busy=1, unless it is forwarded (see Optional Feature).
- in_ready = (!out_valid | out_ready) & !hazard. in_ready depends on the in_* fields; there is no combinational path from wb_* to in_ready except through forwarding.
- Latency: one cycle. On accept, the output register loads the selected operands, rd_addr and rd_we, and out_valid becomes 1 at the next edge.
- Output register when nothing is accepted:
  - If out_ready=1, out_valid drops to 0.
  - If out_valid=1 and out_ready=0, all outputs hold stable.
- Full throughput: one instruction per cycle when there are no hazards.
- Operand selection:
  - op1: X gives 0; RS1 gives the register (or forwarded) value; PC gives in_pc; reserved gives 0.
  - op2: X gives 0; RS2 gives the register (or forwarded) value; IMI/IMS/IMJ/IMU give in_imm; reserved gives 0.
- Read-during-write without forwarding: the array read returns the old value. Such a read is only issued when the source is not busy, so the result is correct.

Optional Feature:
- Macro: REG_OPERAND_FETCH_BYPASS_EN.
- Defined:
  - A used source equal to wb_addr (non-zero) while wb_en=1 takes wb_data.
  - That source does not count as a hazard, even if busy.
  - Back-to-back dependent issue therefore costs no bubble after write-back.
- Undefined:
  - No forwarding path.
  - A busy source stalls through the write-back cycle and issues the following cycle, reading the written array value.

Test Plan:
- Reset with wb_en=1, wb_addr=5, wb_data=0xDEAD asserted together: x5 reads 0 afterwards; out_valid=0; all busy bits clear.
- Write-back x3=0x1234, then issue op1_sel=RS1 rs1=3 and op2_sel=IMI imm=0xFFFFFFF0 → next cycle out_valid=1, out_op1=0x1234, out_op2=0xFFFFFFF0.
- Write-back x0=0x55, then issue op1_sel=RS1 rs1=0 and op2_sel=RS2 rs2=0 → out_op1=0, out_op2=0, no stall.
- Issue rd=7 with rd_we=1, then issue rs1=7 (RS1) → in_ready=0 until write-back of x7=0xABCD:
  - with BYPASS_EN: accepted in the write-back cycle, out_op1=0xABCD;
  - without BYPASS_EN: accepted one cycle later, same value.
- Hold out_ready=0 for 3 cycles with out_valid=1 → outputs stable, in_ready=0. Release → one transfer, then the queued input is accepted the same cycle.
- Issue op1_sel=PC pc=0x80000004 and op2_sel=X while x1 is busy and rs1=1 → no stall; out_op1=0x80000004, out_op2=0.
